// File: rtl/i2c_target.sv
// I2C/SCCB target: oversampled SCL/SDA, START/STOP decode, 7-bit address match,
// sub-address + write data to an external register file, and register read-back.
module i2c_target #(
  parameter logic [6:0] DEV_ADDR = 7'h21,
  parameter int         HOLD     = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_oe,
  output logic [7:0] reg_addr,
  output logic       wr_stb,
  output logic [7:0] wr_data,
  input  logic [7:0] rd_data,
  output logic       busy
);

  localparam int HW = (HOLD < 1) ? 1 : $clog2(HOLD + 1);
  localparam logic [HW-1:0] HOLD_LD = HW'(HOLD);
  localparam logic [HW-1:0] HOLD_ONE = HW'(1);

  typedef enum logic [3:0] {
    IDLE, DEV, DEV_ACK, SUB, SUB_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, IGNORE
  } state_t;

  state_t          state_reg, state_next;
  logic [2:0]      scl_sync_reg, sda_sync_reg;
  logic [2:0]      bit_cnt_reg;
  logic [6:0]      rx_sr_reg;
  logic [7:0]      tx_sr_reg;
  logic [HW-1:0]   hold_cnt_reg;
  logic            rw_reg;
  logic            sda_oe_reg;
  logic            wr_stb_reg;
  logic [7:0]      wr_data_reg;
  logic [7:0]      reg_addr_reg;

  logic scl, sda, scl_rise, scl_fall, start_det, stop_det, byte_last, hold_fire, in_byte;

  // Stage [1] is the synchronized value; stage [2] is its previous sample for edge detection.
  assign scl       = scl_sync_reg[1];
  assign sda       = sda_sync_reg[1];
  assign scl_rise  = scl & ~scl_sync_reg[2];
  assign scl_fall  = ~scl & scl_sync_reg[2];
  assign start_det = scl & scl_sync_reg[2] & sda_sync_reg[2] & ~sda;
  assign stop_det  = scl & scl_sync_reg[2] & ~sda_sync_reg[2] & sda;
  assign byte_last = (bit_cnt_reg == 3'd7);
  assign hold_fire = (hold_cnt_reg == HOLD_ONE);
  assign in_byte   = (state_reg == DEV) || (state_reg == SUB) ||
                     (state_reg == WDATA) || (state_reg == RDATA);

  always_comb begin
    state_next = state_reg;
    if (start_det) begin
      state_next = DEV;
    end else if (stop_det) begin
      state_next = IDLE;
    end else if (scl_rise) begin
      case (state_reg)
        DEV:       if (byte_last) state_next = (rx_sr_reg == DEV_ADDR) ? DEV_ACK : IGNORE;
        DEV_ACK:   state_next = rw_reg ? RDATA : SUB;
        SUB:       if (byte_last) state_next = SUB_ACK;
        SUB_ACK:   state_next = WDATA;
        WDATA:     if (byte_last) state_next = WDATA_ACK;
        WDATA_ACK: state_next = WDATA;
        RDATA:     if (byte_last) state_next = RDATA_ACK;
        RDATA_ACK: state_next = sda ? IGNORE : RDATA;
        default:   state_next = state_reg;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      scl_sync_reg <= 3'b111;
      sda_sync_reg <= 3'b111;
      bit_cnt_reg  <= 3'd0;
      rx_sr_reg    <= 7'd0;
      tx_sr_reg    <= 8'd0;
      hold_cnt_reg <= '0;
      rw_reg       <= 1'b0;
      sda_oe_reg   <= 1'b0;
      wr_stb_reg   <= 1'b0;
      wr_data_reg  <= 8'd0;
      reg_addr_reg <= 8'd0;
    end else begin
      scl_sync_reg <= {scl_sync_reg[1:0], scl_in};
      sda_sync_reg <= {sda_sync_reg[1:0], sda_in};
      state_reg    <= state_next;
      wr_stb_reg   <= 1'b0;
      if (wr_stb_reg) reg_addr_reg <= reg_addr_reg + 8'd1;

      if (start_det || stop_det) begin
        bit_cnt_reg  <= 3'd0;
        hold_cnt_reg <= '0;
        sda_oe_reg   <= 1'b0;
      end else begin
        if (scl_rise) begin
          rx_sr_reg <= {rx_sr_reg[5:0], sda};
          if (in_byte) bit_cnt_reg <= bit_cnt_reg + 3'd1;
          if (state_reg == DEV && byte_last) rw_reg <= sda;
          if (state_reg == SUB && byte_last) reg_addr_reg <= {rx_sr_reg, sda};
          if (state_reg == WDATA && byte_last) begin
            wr_data_reg <= {rx_sr_reg, sda};
            wr_stb_reg  <= 1'b1;
          end
          if (state_reg == RDATA_ACK) reg_addr_reg <= reg_addr_reg + 8'd1;
        end

        if (scl_fall) hold_cnt_reg <= HOLD_LD;
        else if (hold_cnt_reg != '0) hold_cnt_reg <= hold_cnt_reg - HOLD_ONE;

        // SDA only changes here, HOLD cycles into the SCL low phase.
        if (hold_fire) begin
          case (state_reg)
            DEV_ACK, SUB_ACK, WDATA_ACK: sda_oe_reg <= 1'b1;
            RDATA: begin
              if (bit_cnt_reg == 3'd0) begin
                tx_sr_reg  <= rd_data;
                sda_oe_reg <= ~rd_data[7];
              end else begin
                sda_oe_reg <= ~tx_sr_reg[3'd7 - bit_cnt_reg];
              end
            end
            default: sda_oe_reg <= 1'b0;
          endcase
        end
      end
    end
  end

  assign sda_oe   = sda_oe_reg;
  assign reg_addr = reg_addr_reg;
  assign wr_stb   = wr_stb_reg;
  assign wr_data  = wr_data_reg;
  assign busy     = (state_reg != IDLE);

endmodule

// File: tb/tb_i2c_target.sv
// Bench for i2c_target: bus-level I2C master, transaction-level register model,
// and a per-cycle monitor checking write strobes and SDA timing.
module tb_i2c_target;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       scl_m = 1'b1;
  logic       sda_m = 1'b1;
  wire        sda_line;
  logic       sda_oe, wr_stb, busy;
  logic [7:0] reg_addr, wr_data;
  wire  [7:0] rd_data;

  assign sda_line = sda_m & ~sda_oe;
  assign rd_data  = reg_addr ^ 8'h5A;

  always #5 clk = ~clk;

  i2c_target #(.DEV_ADDR(7'h21), .HOLD(4)) dut (
    .clk(clk), .rst_n(rst_n), .scl_in(scl_m), .sda_in(sda_line),
    .sda_oe(sda_oe), .reg_addr(reg_addr), .wr_stb(wr_stb),
    .wr_data(wr_data), .rd_data(rd_data), .busy(busy)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Register-file model: selected device, current sub-address, expected writes
  logic [7:0]  mdl_addr = 8'h00;
  bit          mdl_sel = 1'b0;
  logic [15:0] exp_wr[$];

  logic oe_prev = 1'b0;
  logic stb_prev = 1'b0;
  bit   oe_seen = 1'b0;

  always @(negedge clk) begin
    if (wr_stb) begin
      if (exp_wr.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL wr_unexpected: got addr=0x%0h data=0x%0h expected no strobe", reg_addr, wr_data);
      end else begin
        chk("wr_addr_data", {16'h0, reg_addr, wr_data}, {16'h0, exp_wr.pop_front()});
      end
      chk("wr_stb_single", stb_prev, 1'b0);
    end
    if (sda_oe !== oe_prev) chk("oe_change_scl_low", scl_m, 1'b0);
    if (sda_oe) oe_seen = 1'b1;
    oe_prev  = sda_oe;
    stb_prev = wr_stb;
  end

  task automatic q();
    repeat (10) @(posedge clk);
    #1;
  endtask

  task automatic bit_xfer(input logic b, output logic r);
    sda_m = b; q();
    scl_m = 1'b1; q();
    r = sda_line; q();
    scl_m = 1'b0; q();
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; q();
    scl_m = 1'b1; q();
    sda_m = 1'b0; q();
    scl_m = 1'b0; q();
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; q();
    scl_m = 1'b1; q();
    sda_m = 1'b1; q(); q();
  endtask

  task automatic wr_byte(input logic [7:0] b, output logic ack);
    logic r;
    for (int i = 7; i >= 0; i--) bit_xfer(b[i], r);
    bit_xfer(1'b1, r);
    ack = ~r;
  endtask

  task automatic rd_byte(input logic ack, output logic [7:0] d);
    logic r;
    for (int i = 7; i >= 0; i--) begin
      bit_xfer(1'b1, r);
      d[i] = r;
    end
    bit_xfer(~ack, r);
  endtask

  task automatic m_addr(input logic [7:0] b);
    logic ack;
    mdl_sel = (b[7:1] == 7'h21);
    wr_byte(b, ack);
    chk("dev_ack", ack, mdl_sel);
  endtask

  task automatic m_sub(input logic [7:0] b);
    logic ack;
    wr_byte(b, ack);
    chk("sub_ack", ack, mdl_sel);
    if (mdl_sel) mdl_addr = b;
  endtask

  task automatic m_data(input logic [7:0] b);
    logic ack;
    if (mdl_sel) begin
      exp_wr.push_back({mdl_addr, b});
      mdl_addr = mdl_addr + 8'd1;
    end
    wr_byte(b, ack);
    chk("data_ack", ack, mdl_sel);
  endtask

  task automatic m_read(input logic ack, output logic [7:0] d);
    rd_byte(ack, d);
    chk("rd_data", d, mdl_addr ^ 8'h5A);
    mdl_addr = mdl_addr + 8'd1;
    if (!ack) mdl_sel = 1'b0;
  endtask

  task automatic chk_idle(input string nm);
    chk({nm, "_busy"}, busy, 1'b0);
    chk({nm, "_sda_oe"}, sda_oe, 1'b0);
    chk({nm, "_reg_addr"}, reg_addr, mdl_addr);
    chk({nm, "_wr_pending"}, exp_wr.size(), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end

  initial begin
    logic       r;
    logic [7:0] d;

    repeat (5) @(posedge clk);
    #1;
    chk("rst_sda_oe", sda_oe, 1'b0);
    chk("rst_reg_addr", reg_addr, 8'h00);
    chk("rst_wr_stb", wr_stb, 1'b0);
    chk("rst_wr_data", wr_data, 8'h00);
    chk("rst_busy", busy, 1'b0);
    rst_n = 1'b1;
    q();

    // 1: simple write
    i2c_start();
    chk("t1_busy_on", busy, 1'b1);
    m_addr(8'h42);
    m_sub(8'h12);
    m_data(8'h80);
    i2c_stop();
    chk("t1_reg_addr_lit", reg_addr, 8'h13);
    chk_idle("t1");
    $display("t1 write 42,12,80: reg_addr=0x%0h", reg_addr);

    // 2: foreign address, must stay silent
    oe_seen = 1'b0;
    i2c_start();
    m_addr(8'h44);
    m_sub(8'h10);
    m_data(8'h20);
    i2c_stop();
    chk("t2_no_drive", oe_seen, 1'b0);
    chk("t2_reg_addr_lit", reg_addr, 8'h13);
    chk_idle("t2");
    $display("t2 foreign address 44: reg_addr=0x%0h", reg_addr);

    // 3: auto-increment wrap
    i2c_start();
    m_addr(8'h42);
    m_sub(8'hFE);
    m_data(8'hA1);
    m_data(8'hA2);
    m_data(8'hA3);
    i2c_stop();
    chk("t3_reg_addr_lit", reg_addr, 8'h01);
    chk_idle("t3");
    $display("t3 wrap write: reg_addr=0x%0h", reg_addr);

    // 4: write sub-address, repeated START, read two bytes
    i2c_start();
    m_addr(8'h42);
    m_sub(8'h0A);
    i2c_start();
    chk("t4_rs_reg_addr", reg_addr, 8'h0A);
    m_addr(8'h43);
    m_read(1'b1, d);
    chk("t4_byte0_lit", d, 8'h50);
    m_read(1'b0, d);
    chk("t4_byte1_lit", d, 8'h51);
    oe_seen = 1'b0;
    for (int i = 0; i < 4; i++) bit_xfer(1'b1, r);
    chk("t4_ignore_no_drive", oe_seen, 1'b0);
    chk("t4_ignore_busy", busy, 1'b1);
    i2c_stop();
    chk("t4_reg_addr_lit", reg_addr, 8'h0C);
    chk_idle("t4");
    $display("t4 read 0A: reg_addr=0x%0h", reg_addr);

    // 5: reset in the middle of a data byte
    i2c_start();
    m_addr(8'h42);
    m_sub(8'h20);
    bit_xfer(1'b1, r);
    bit_xfer(1'b0, r);
    bit_xfer(1'b1, r);
    bit_xfer(1'b1, r);
    sda_m = 1'b0; q();
    scl_m = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("t5_sda_oe", sda_oe, 1'b0);
    chk("t5_reg_addr", reg_addr, 8'h00);
    chk("t5_wr_stb", wr_stb, 1'b0);
    chk("t5_wr_data", wr_data, 8'h00);
    chk("t5_busy", busy, 1'b0);
    sda_m = 1'b1; q();
    rst_n = 1'b1; q(); q();
    mdl_addr = 8'h00;
    mdl_sel  = 1'b0;
    i2c_start();
    m_addr(8'h42);
    m_sub(8'h05);
    m_data(8'h77);
    i2c_stop();
    chk("t5_after_reg_addr_lit", reg_addr, 8'h06);
    chk_idle("t5");
    $display("t5 reset mid-byte then write 05,77: reg_addr=0x%0h", reg_addr);

    // 6: STOP mid data byte
    i2c_start();
    m_addr(8'h42);
    m_sub(8'h30);
    for (int i = 0; i < 5; i++) bit_xfer(i[0], r);
    i2c_stop();
    chk("t6_reg_addr_lit", reg_addr, 8'h30);
    chk_idle("t6_abort");
    i2c_start();
    m_addr(8'h42);
    m_sub(8'h31);
    m_data(8'h55);
    i2c_stop();
    chk("t6_next_reg_addr_lit", reg_addr, 8'h32);
    chk_idle("t6");
    $display("t6 stop mid-byte then write 31,55: reg_addr=0x%0h", reg_addr);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
